controlador_multiciclo: RTL

Parametrised multi-cycle control unit for the simple processor datapath: the next generation of the combinational step decoder. It owns its own step counter and replaces the external counter. It adds a memory ready handshake with wait states, an `and` instruction and illegal-opcode trapping. It drives the datapath bus multiplexer, register load enables, ALU operation, PC increment and memory write.

---
 rtl/controlador_multiciclo.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/controlador_multiciclo.sv
// controlador_multiciclo: multi-cycle control unit with memory wait states and illegal-opcode trap
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   run                   execution enable, level-sensitive
//   ir, g_out, mem_ready  instruction, G register value, memory handshake
//   done                  final step of the current instruction
//   mux_sel               bus source (registers, DIN, G, const 0, const 1)
//   regs_in               load enables (registers, A, G, ADDR, DOUT, IR)
//   alu_op, incr_pc       ALU operation, PC increment strobe
//   mem_wr, illegal       memory write strobe, sticky illegal-opcode flag
module controlador_multiciclo #(
   parameter int DATA_W   = 16,
   parameter int NREGS    = 8,
   parameter int REG_BITS = $clog2(NREGS),
   parameter int IR_W     = 4 + 2*REG_BITS,
   parameter int SEL_W    = $clog2(NREGS+4)
)(
   input  logic              clock,
   input  logic              reset,
   input  logic              run,
   input  logic [IR_W-1:0]   ir,
   input  logic [DATA_W-1:0] g_out,
   input  logic              mem_ready,
   output logic              done,
   output logic [SEL_W-1:0]  mux_sel,
   output logic [NREGS+4:0]  regs_in,
   output logic [2:0]        alu_op,
   output logic              incr_pc,
   output logic              mem_wr,
   output logic              illegal
);
   localparam int RW = NREGS + 5;
   localparam logic [2:0] IDLE = 3'd0, T0 = 3'd1, T1 = 3'd2, T2 = 3'd3,
                          T3 = 3'd4, T4 = 3'd5, HALT = 3'd6;
   localparam logic [3:0] OP_MV = 4'b0000, OP_MVI = 4'b0001, OP_SUB = 4'b0011,
                          OP_LD = 4'b0100, OP_ST = 4'b0101, OP_MVNZ = 4'b0110,
                          OP_OR = 4'b0111, OP_SLT = 4'b1000, OP_SLL = 4'b1001,
                          OP_SRL = 4'b1010, OP_AND = 4'b1011;
   localparam logic [SEL_W-1:0] SEL_PC  = SEL_W'(NREGS-1),
                                SEL_DIN = SEL_W'(NREGS),
                                SEL_G   = SEL_W'(NREGS+1),
                                SEL_0   = SEL_W'(NREGS+2),
                                SEL_1   = SEL_W'(NREGS+3);
   localparam int A_IN = NREGS, G_IN = NREGS+1, ADDR_IN = NREGS+2,
                  DOUT_IN = NREGS+3, IR_IN = NREGS+4;

   logic [2:0] state, next_state;
   logic       ill_q;

   logic [3:0]          op;
   logic [REG_BITS-1:0] rx, ry;
   logic                is_ill;
   logic [2:0]          alu_code;

   assign op     = ir[IR_W-1 -: 4];
   assign rx     = ir[2*REG_BITS-1 -: REG_BITS];
   assign ry     = ir[REG_BITS-1:0];
   assign is_ill = op[3] & op[2];

   // slt subtracts; the result sign is then turned into constant 0/1 in T4
   assign alu_code = (op == OP_SUB || op == OP_SLT) ? 3'b001 :
                     (op == OP_OR)  ? 3'b010 :
                     (op == OP_SLL) ? 3'b011 :
                     (op == OP_SRL) ? 3'b100 :
                     (op == OP_AND) ? 3'b101 : 3'b000;

   function automatic logic [RW-1:0] bit_at(input int i);
      return RW'(1) << i;
   endfunction

   always_comb begin
      next_state = state;
      done       = 1'b0;
      mux_sel    = '0;
      regs_in    = '0;
      alu_op     = 3'b111;
      incr_pc    = 1'b0;
      mem_wr     = 1'b0;
      if (!reset) begin
         case (state)
            IDLE: next_state = run ? T0 : IDLE;
            T0: begin
               mux_sel    = SEL_PC;
               regs_in    = bit_at(ADDR_IN);
               incr_pc    = 1'b1;
               next_state = T1;
            end
            T1: if (mem_ready) begin
               regs_in    = bit_at(IR_IN);
               next_state = T2;
            end
            T2: if (is_ill) next_state = HALT;
            else case (op)
               OP_MV: begin
                  mux_sel = SEL_W'(ry);
                  regs_in = bit_at(int'(rx));
                  done    = 1'b1;
               end
               OP_MVI: begin
                  mux_sel    = SEL_PC;
                  regs_in    = bit_at(ADDR_IN);
                  incr_pc    = 1'b1;
                  next_state = T3;
               end
               OP_LD, OP_ST: begin
                  mux_sel    = SEL_W'(ry);
                  regs_in    = bit_at(ADDR_IN);
                  next_state = T3;
               end
               OP_MVNZ: begin
                  mux_sel = SEL_W'(ry);
                  regs_in = (g_out != '0) ? bit_at(int'(rx)) : '0;
                  done    = 1'b1;
               end
               default: begin
                  mux_sel    = SEL_W'(rx);
                  regs_in    = bit_at(A_IN);
                  next_state = T3;
               end
            endcase
            T3: case (op)
               OP_MVI, OP_LD: if (mem_ready) begin
                  mux_sel = SEL_DIN;
                  regs_in = bit_at(int'(rx));
                  done    = 1'b1;
               end
               OP_ST: begin
                  mux_sel = SEL_W'(rx);
                  regs_in = bit_at(DOUT_IN);
                  mem_wr  = 1'b1;
                  done    = mem_ready;
               end
               default: begin
                  mux_sel    = SEL_W'(ry);
                  regs_in    = bit_at(G_IN);
                  alu_op     = alu_code;
                  next_state = T4;
               end
            endcase
            T4: begin
               regs_in = bit_at(int'(rx));
               done    = 1'b1;
               mux_sel = (op != OP_SLT) ? SEL_G : g_out[DATA_W-1] ? SEL_1 : SEL_0;
            end
            HALT: next_state = HALT;
            default: next_state = IDLE;
         endcase
         if (done) next_state = run ? T0 : IDLE;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         ill_q <= 1'b0;
      end else begin
         state <= next_state;
         if (state == T2 && is_ill) ill_q <= 1'b1;
      end
   end

   assign illegal = ill_q & ~reset;
endmodule
